rect_ctl: RTL

Frame-synchronous position controller for the rectangle sprite overlay. Generates the `xpos`/`ypos` coordinates consumed by the rectangle drawing stage. Tracks the mouse while idle, drops the rectangle under constant acceleration after a left click, and parks it on a floor line. Positions change only at vertical-blank start, so a frame is never drawn with a mid-scan position change.

---
 rtl/rect_ctl_if.sv | 21 ++
 rtl/rect_ctl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/rect_ctl_if.sv
// Bus bundle between the timing/mouse side and rect_ctl: frame blank, mouse
// inputs and the registered rectangle position/state outputs.
interface rect_ctl_if;
   logic        vblnk_in;
   logic [11:0] mouse_xpos;
   logic [11:0] mouse_ypos;
   logic        mouse_left;
   logic [11:0] xpos;
   logic [11:0] ypos;
   logic [1:0]  state_out;

   modport master (
      output vblnk_in, mouse_xpos, mouse_ypos, mouse_left,
      input  xpos, ypos, state_out
   );

   modport slave (
      input  vblnk_in, mouse_xpos, mouse_ypos, mouse_left,
      output xpos, ypos, state_out
   );
endinterface

// File: rtl/rect_ctl.sv
// Frame-synchronous rectangle position controller: mouse tracking, gravity fall
// and floor parking. Define RECT_CTL_BOUNCE_EN to compile the bounce (RISE) state.
module rect_ctl #(
   parameter int X_MAX      = 752,
   parameter int FLOOR_Y    = 536,
   parameter int ACCEL      = 1,
   parameter int VMAX       = 32,
   parameter int BOUNCE_MIN = 4
) (
   input  logic       pclk,
   input  logic       rst,
   rect_ctl_if.slave  bus
);

   localparam logic [12:0] X_MAX_W = 13'(X_MAX);
   localparam logic [12:0] FLOOR_W = 13'(FLOOR_Y);
   localparam logic [12:0] ACCEL_W = 13'(ACCEL);
   localparam logic [12:0] VMAX_W  = 13'(VMAX);
`ifdef RECT_CTL_BOUNCE_EN
   localparam logic [12:0] BMIN_W  = 13'(BOUNCE_MIN);
`endif

`ifdef RECT_CTL_BOUNCE_EN
   typedef enum logic [1:0] {IDLE = 2'd0, FALL = 2'd1, LANDED = 2'd2, RISE = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, FALL = 2'd1, LANDED = 2'd2} state_t;
`endif

   state_t      state, state_nxt;
   logic [11:0] xpos_r, xpos_nxt;
   logic [11:0] ypos_r, ypos_nxt;
   logic [5:0]  vel, vel_nxt;
   logic        vblnk_q, left_q;
   logic        tick, click;
   logic [12:0] fall_sum;
`ifdef RECT_CTL_BOUNCE_EN
   logic signed [12:0] rise_diff;
`endif

   // Upper clamp of a 13-bit sum into the 12-bit position range.
   function automatic logic [11:0] clamp_hi(input logic [12:0] v, input logic [12:0] lim);
      return (v > lim) ? lim[11:0] : v[11:0];
   endfunction

   function automatic logic [5:0] sat_vel(input logic [12:0] v);
      return (v > VMAX_W) ? VMAX_W[5:0] : v[5:0];
   endfunction

`ifdef RECT_CTL_BOUNCE_EN
   function automatic logic [11:0] floor_zero(input logic signed [12:0] v);
      return (v < 0) ? 12'd0 : v[11:0];
   endfunction
`endif

   assign tick  = bus.vblnk_in & ~vblnk_q;
   assign click = bus.mouse_left & ~left_q;

   assign bus.xpos      = xpos_r;
   assign bus.ypos      = ypos_r;
   assign bus.state_out = state;

   always_comb begin
      state_nxt = state;
      xpos_nxt  = xpos_r;
      ypos_nxt  = ypos_r;
      vel_nxt   = vel;
      fall_sum  = {1'b0, ypos_r} + {7'b0, vel};
`ifdef RECT_CTL_BOUNCE_EN
      rise_diff = $signed({1'b0, ypos_r}) - $signed({7'b0, vel});
`endif
      case (state)
         IDLE: begin
            if (tick) begin
               xpos_nxt = clamp_hi({1'b0, bus.mouse_xpos}, X_MAX_W);
               ypos_nxt = clamp_hi({1'b0, bus.mouse_ypos}, FLOOR_W);
            end
            if (click) begin
               state_nxt = FALL;
               vel_nxt   = '0;
            end
         end
         FALL: begin
            if (tick) begin
               if (fall_sum >= FLOOR_W) begin
                  ypos_nxt = FLOOR_W[11:0];
`ifdef RECT_CTL_BOUNCE_EN
                  if ({7'b0, vel} >= BMIN_W) begin
                     state_nxt = RISE;
                     vel_nxt   = vel >> 1;
                  end else begin
                     state_nxt = LANDED;
                  end
`else
                  state_nxt = LANDED;
`endif
               end else begin
                  // Position advances by the velocity held before this tick.
                  ypos_nxt = fall_sum[11:0];
                  vel_nxt  = sat_vel({7'b0, vel} + ACCEL_W);
               end
            end
         end
         LANDED: begin
            if (click) state_nxt = IDLE;
         end
`ifdef RECT_CTL_BOUNCE_EN
         RISE: begin
            if (tick) begin
               ypos_nxt = floor_zero(rise_diff);
               if ({7'b0, vel} <= ACCEL_W) begin
                  vel_nxt   = '0;
                  state_nxt = FALL;
               end else begin
                  vel_nxt = 6'({7'b0, vel} - ACCEL_W);
               end
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         state   <= IDLE;
         xpos_r  <= '0;
         ypos_r  <= '0;
         vel     <= '0;
         vblnk_q <= 1'b0;
         left_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         xpos_r  <= xpos_nxt;
         ypos_r  <= ypos_nxt;
         vel     <= vel_nxt;
         vblnk_q <= bus.vblnk_in;
         left_q  <= bus.mouse_left;
      end
   end

endmodule
